// File: rtl/uart_rx_if.sv
// Serial line and receive-side outputs of the 8-N-1 UART receiver.
// The receiver is the slave; the line driver/consumer is the master.
interface uart_rx_if;
   logic       i_Rx_Serial;
   logic       o_Rx_DV;
   logic [7:0] o_Rx_Byte;
   logic       o_Rx_Busy;
   logic       o_Frame_Err;

   modport slave (
      input  i_Rx_Serial,
      output o_Rx_DV,
      output o_Rx_Byte,
      output o_Rx_Busy,
      output o_Frame_Err
   );

   modport master (
      output i_Rx_Serial,
      input  o_Rx_DV,
      input  o_Rx_Byte,
      input  o_Rx_Busy,
      input  o_Frame_Err
   );
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: synchronised line, mid-bit start validation,
// centre sampling, one-cycle byte strobe and framing-error strobe.
module uart_rx #(
   parameter int CLKS_PER_BIT = 260
) (
   input  logic     i_Clock,
   input  logic     i_Rst_n,
   uart_rx_if.slave rx
);

   localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      s_IDLE         = 3'd0,
      s_RX_START_BIT = 3'd1,
      s_RX_DATA_BITS = 3'd2,
      s_RX_STOP_BIT  = 3'd3,
      s_CLEANUP      = 3'd4
   } state_t;

   logic        r_Rx_Meta;
   logic        r_Rx_Sync;
   logic        r_Rx_Prev;
   logic [1:0]  r_Warm;

   state_t      r_State;
   state_t      w_State_Nxt;
   logic [15:0] r_Clk_Cnt;
   logic [15:0] w_Clk_Cnt_Nxt;
   logic [2:0]  r_Bit_Idx;
   logic [2:0]  w_Bit_Idx_Nxt;
   logic [7:0]  r_Shift;
   logic [7:0]  w_Shift_Nxt;
   logic [7:0]  r_Rx_Byte;
   logic [7:0]  w_Rx_Byte_Nxt;
   logic        r_Rx_DV;
   logic        w_Rx_DV_Nxt;
   logic        r_Frame_Err;
   logic        w_Frame_Err_Nxt;

   logic        w_Fall;
   logic        w_Cnt_Half;
   logic        w_Cnt_Last;

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         r_Rx_Meta <= 1'b1;
         r_Rx_Sync <= 1'b1;
         r_Rx_Prev <= 1'b1;
         r_Warm    <= 2'd0;
      end else begin
         r_Rx_Meta <= rx.i_Rx_Serial;
         r_Rx_Sync <= r_Rx_Meta;
         r_Rx_Prev <= r_Rx_Sync;
         if (r_Warm != 2'd3)
            r_Warm <= r_Warm + 2'd1;
      end
   end

   // Edges count only once Sync and Prev both hold real line samples,
   // so a line that is low coming out of reset never starts a frame.
   assign w_Fall     = (r_Warm == 2'd3) & r_Rx_Prev & ~r_Rx_Sync;
   assign w_Cnt_Half = (r_Clk_Cnt == HALF);
   assign w_Cnt_Last = (r_Clk_Cnt == LAST);

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         r_State     <= s_IDLE;
         r_Clk_Cnt   <= 16'd0;
         r_Bit_Idx   <= 3'd0;
         r_Shift     <= 8'h00;
         r_Rx_Byte   <= 8'h00;
         r_Rx_DV     <= 1'b0;
         r_Frame_Err <= 1'b0;
      end else begin
         r_State     <= w_State_Nxt;
         r_Clk_Cnt   <= w_Clk_Cnt_Nxt;
         r_Bit_Idx   <= w_Bit_Idx_Nxt;
         r_Shift     <= w_Shift_Nxt;
         r_Rx_Byte   <= w_Rx_Byte_Nxt;
         r_Rx_DV     <= w_Rx_DV_Nxt;
         r_Frame_Err <= w_Frame_Err_Nxt;
      end
   end

   always_comb begin
      w_State_Nxt     = r_State;
      w_Clk_Cnt_Nxt   = r_Clk_Cnt;
      w_Bit_Idx_Nxt   = r_Bit_Idx;
      w_Shift_Nxt     = r_Shift;
      w_Rx_Byte_Nxt   = r_Rx_Byte;
      w_Rx_DV_Nxt     = 1'b0;
      w_Frame_Err_Nxt = 1'b0;

      case (r_State)
         s_IDLE: begin
            w_Clk_Cnt_Nxt = 16'd0;
            w_Bit_Idx_Nxt = 3'd0;
            if (w_Fall)
               w_State_Nxt = s_RX_START_BIT;
         end

         s_RX_START_BIT: begin
            if (w_Cnt_Half) begin
               w_Clk_Cnt_Nxt = 16'd0;
               w_State_Nxt   = r_Rx_Sync ? s_IDLE : s_RX_DATA_BITS;
            end else begin
               w_Clk_Cnt_Nxt = r_Clk_Cnt + 16'd1;
            end
         end

         s_RX_DATA_BITS: begin
            if (w_Cnt_Last) begin
               w_Clk_Cnt_Nxt          = 16'd0;
               w_Shift_Nxt[r_Bit_Idx] = r_Rx_Sync;
               if (r_Bit_Idx == 3'd7) begin
                  w_Bit_Idx_Nxt = 3'd0;
                  w_State_Nxt   = s_RX_STOP_BIT;
               end else begin
                  w_Bit_Idx_Nxt = r_Bit_Idx + 3'd1;
               end
            end else begin
               w_Clk_Cnt_Nxt = r_Clk_Cnt + 16'd1;
            end
         end

         s_RX_STOP_BIT: begin
            if (w_Cnt_Last) begin
               w_Clk_Cnt_Nxt = 16'd0;
               w_State_Nxt   = s_CLEANUP;
               if (r_Rx_Sync) begin
                  w_Rx_Byte_Nxt = r_Shift;
                  w_Rx_DV_Nxt   = 1'b1;
               end else begin
                  w_Frame_Err_Nxt = 1'b1;
               end
            end else begin
               w_Clk_Cnt_Nxt = r_Clk_Cnt + 16'd1;
            end
         end

         s_CLEANUP: begin
            w_Clk_Cnt_Nxt = 16'd0;
            w_State_Nxt   = s_IDLE;
         end

         default: begin
            w_Clk_Cnt_Nxt = 16'd0;
            w_Bit_Idx_Nxt = 3'd0;
            w_State_Nxt   = s_IDLE;
         end
      endcase
   end

   assign rx.o_Rx_DV     = r_Rx_DV;
   assign rx.o_Rx_Byte   = r_Rx_Byte;
   assign rx.o_Frame_Err = r_Frame_Err;
   assign rx.o_Rx_Busy   = (r_State != s_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: driver queues expected pulses,
// a negedge monitor pops and compares whenever DV or Frame_Err fires.
module tb_uart_rx;

   localparam int CPB  = 260;
   localparam int HALF = (CPB - 1) / 2;
   localparam int LAT  = 4 + HALF + 9 * CPB;

   typedef struct {
      bit         err;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t m_e;
   logic [7:0] held;

   uart_rx_if rx();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock (clk),
      .i_Rst_n (rst_n),
      .rx      (rx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rx.o_Rx_DV === 1'b1 || rx.o_Frame_Err === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: dv=%b err=%b byte=%h cycle %0d, expected no pulse",
                     rx.o_Rx_DV, rx.o_Frame_Err, rx.o_Rx_Byte, cyc);
         end else begin
            m_e = sb.pop_front();
            chk("pulse_dv", {31'd0, rx.o_Rx_DV}, {31'd0, !m_e.err});
            chk("pulse_err", {31'd0, rx.o_Frame_Err}, {31'd0, m_e.err});
            chk("rx_byte", {24'd0, rx.o_Rx_Byte}, {24'd0, m_e.data});
            chk("pulse_cycle", cyc, m_e.cyc);
            chk("busy_at_pulse", {31'd0, rx.o_Rx_Busy}, 32'd1);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic line_bit(input logic v);
      rx.i_Rx_Serial = v;
      wait_cyc(CPB);
   endtask

   task automatic idle(input int n);
      rx.i_Rx_Serial = 1'b1;
      wait_cyc(n);
   endtask

   // Called #1 after a posedge; returns aligned the same way.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      exp_t e;
      e.cyc = cyc + LAT;
      if (stop) begin
         e.err = 1'b0;
         e.data = d;
         held = d;
      end else begin
         e.err = 1'b1;
         e.data = held;
      end
      sb.push_back(e);
      line_bit(1'b0);
      for (int i = 0; i < 8; i++)
         line_bit(d[i]);
      line_bit(stop);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dv"}, {31'd0, rx.o_Rx_DV}, 32'd0);
      chk({tag, "_err"}, {31'd0, rx.o_Frame_Err}, 32'd0);
      chk({tag, "_byte"}, {24'd0, rx.o_Rx_Byte}, 32'h00);
      chk({tag, "_busy"}, {31'd0, rx.o_Rx_Busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] f0;
      f0 = 8'hF0;
      held = 8'h00;
      rx.i_Rx_Serial = 1'b1;
      rst_n = 1'b0;
      wait_cyc(3);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      idle(20);

      // Nominal A5 frame
      send_frame(8'hA5, 1'b1);
      idle(100);
      chk("sb_empty_nominal", sb.size(), 32'd0);

      // Short low glitch: rejected at mid start bit
      rx.i_Rx_Serial = 1'b0;
      wait_cyc(50);
      chk("glitch_busy_mid", {31'd0, rx.o_Rx_Busy}, 32'd1);
      rx.i_Rx_Serial = 1'b1;
      wait_cyc(85);
      chk("glitch_busy_drop", {31'd0, rx.o_Rx_Busy}, 32'd0);
      chk("glitch_byte_kept", {24'd0, rx.o_Rx_Byte}, 32'hA5);
      idle(200);

      // Good 11 then 3C with stop bit low
      send_frame(8'h11, 1'b1);
      send_frame(8'h3C, 1'b0);
      idle(300);
      chk("ferr_byte_kept", {24'd0, rx.o_Rx_Byte}, 32'h11);
      chk("sb_empty_ferr", sb.size(), 32'd0);

      // Back-to-back frames
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h5A, 1'b1);
      idle(300);
      chk("b2b_last_byte", {24'd0, rx.o_Rx_Byte}, 32'h5A);
      chk("sb_empty_b2b", sb.size(), 32'd0);

      // Reset during bit 3 of F0
      line_bit(1'b0);
      for (int i = 0; i < 3; i++)
         line_bit(f0[i]);
      rx.i_Rx_Serial = f0[3];
      wait_cyc(100);
      rst_n = 1'b0;
      wait_cyc(3);
      chk_reset_vals("midrst");
      rst_n = 1'b1;
      held = 8'h00;
      wait_cyc(CPB - 103);
      for (int i = 4; i < 8; i++)
         line_bit(f0[i]);
      line_bit(1'b1);
      idle(300);
      chk("midrst_busy_after", {31'd0, rx.o_Rx_Busy}, 32'd0);
      chk("midrst_byte_after", {24'd0, rx.o_Rx_Byte}, 32'h00);
      send_frame(8'hC3, 1'b1);
      idle(100);
      chk("c3_byte", {24'd0, rx.o_Rx_Byte}, 32'hC3);

      // Line stuck low out of reset
      rx.i_Rx_Serial = 1'b0;
      rst_n = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      held = 8'h00;
      wait_cyc(2500);
      chk("stuck_busy_mid", {31'd0, rx.o_Rx_Busy}, 32'd0);
      wait_cyc(2500);
      chk("stuck_busy_end", {31'd0, rx.o_Rx_Busy}, 32'd0);
      chk("stuck_byte", {24'd0, rx.o_Rx_Byte}, 32'h00);
      idle(260);
      send_frame(8'h7E, 1'b1);
      idle(200);
      chk("final_byte", {24'd0, rx.o_Rx_Byte}, 32'h7E);
      chk("sb_empty_final", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
